// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, word-addressed instruction memory and a valid/ready
// instruction output with redirect and halt. Define IFU_PERF_CNT_EN for fetch/stall counters.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic                          instr_ready,
  output logic                          instr_valid,
  output logic [31:0]                   instr_word,
  output logic [31:0]                   instr_pc,
  output logic                          misalign_err,
  output logic                          halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_fetch_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] rd_word;
  logic        accept;
  logic        load_due;
  logic        out_of_range;

  assign accept       = instr_valid && instr_ready;
  assign load_due     = (state == RUN) && (!instr_valid || instr_ready);
  assign out_of_range = {2'b00, pc[31:2]} >= 32'(IMEM_DEPTH);
  assign rd_word      = imem[pc[2 +: AW]];

  // Memory has no reset; the nonblocking write gives read-old-data on a same-address collision.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      instr_valid  <= 1'b0;
      instr_word   <= '0;
      instr_pc     <= '0;
      misalign_err <= 1'b0;
      halted       <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (redirect_valid) begin
        // Anything still presented is either consumed this cycle or discarded.
        pc           <= {redirect_pc[31:2], 2'b00};
        instr_valid  <= 1'b0;
        misalign_err <= (redirect_pc[1:0] != 2'b00);
        halted       <= 1'b0;
        state        <= RUN;
      end else begin
        case (state)
          BOOT: state <= RUN;
          RUN: begin
            if (load_due) begin
              if (out_of_range) begin
                instr_valid <= 1'b0;
                halted      <= 1'b1;
                state       <= HALT;
              end else begin
                instr_word  <= rd_word;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + 32'd4;
              end
            end
          end
          HALT: begin
            if (accept) begin
              instr_valid <= 1'b0;
            end
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (instr_valid && !instr_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// run scored against a transaction-level model of the instruction stream.
module tb_instr_fetch_unit;

  localparam logic [31:0] ADD = 32'h003100B3;
  localparam logic [31:0] SUB = 32'h403100B3;
  localparam logic [31:0] XOR = 32'h003140B3;
  localparam logic [31:0] OR  = 32'h003160B3;

  logic        clk = 1'b0;
  logic        reset_n, reset2_n;
  logic        we, we2;
  logic [3:0]  waddr;
  logic [1:0]  waddr2;
  logic [31:0] wdata;
  logic        rv, rdy, rv2, rdy2;
  logic [31:0] rpc, rpc2;

  logic        valid, misalign, halted;
  logic [31:0] word, ipc;
  logic        valid2, misalign2, halted2;
  logic [31:0] word2, ipc2;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, fetch_cnt2, stall_cnt2;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.IMEM_DEPTH(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .imem_we(we), .imem_waddr(waddr), .imem_wdata(wdata),
    .redirect_valid(rv), .redirect_pc(rpc), .instr_ready(rdy),
    .instr_valid(valid), .instr_word(word), .instr_pc(ipc),
    .misalign_err(misalign), .halted(halted)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(fetch_cnt), .perf_stall_cnt(stall_cnt)
`endif
  );

  instr_fetch_unit #(.IMEM_DEPTH(4), .RESET_PC(32'h0)) dut2 (
    .clk(clk), .reset_n(reset2_n), .imem_we(we2), .imem_waddr(waddr2), .imem_wdata(wdata),
    .redirect_valid(rv2), .redirect_pc(rpc2), .instr_ready(rdy2),
    .instr_valid(valid2), .instr_word(word2), .instr_pc(ipc2),
    .misalign_err(misalign2), .halted(halted2)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(fetch_cnt2), .perf_stall_cnt(stall_cnt2)
`endif
  );

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] mem [16];
  logic [31:0] mem2 [4];
  logic [31:0] next_pc;
  logic        p_valid, p_halted;
  logic [31:0] p_pc, p_word;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; reset2_n = 1'b0;
    rv = 1'b0; rpc = '0; rdy = 1'b1;
    rv2 = 1'b0; rpc2 = '0; rdy2 = 1'b1;
    we = 1'b0; we2 = 1'b0; waddr = '0; waddr2 = '0; wdata = '0;
    mem[0] = ADD; mem[1] = SUB; mem[2] = XOR; mem[3] = OR;
    for (int k = 4; k < 16; k++) mem[k] = $urandom;
    for (int k = 0; k < 4; k++) mem2[k] = mem[k];

    // program load while both units are held in reset
    for (int k = 0; k < 16; k++) begin
      we = 1'b1; we2 = (k < 4); waddr = 4'(k); waddr2 = 2'(k); wdata = mem[k];
      tick();
    end
    we = 1'b0; we2 = 1'b0;
    tick();
    check("rst_valid", valid, 0);
    check("rst_word", word, 0);
    check("rst_pc", ipc, 0);
    check("rst_misalign", misalign, 0);
    check("rst_halted", halted, 0);
`ifdef IFU_PERF_CNT_EN
    check("rst_fetch_cnt", fetch_cnt, 0);
    check("rst_stall_cnt", stall_cnt, 0);
`endif

    // sequential fetch, then a 3-cycle stall on pc=8
    reset_n = 1'b1;
    tick();
    check("boot_nofetch", valid, 0);
    tick(); check("seq0_valid", valid, 1); check("seq0_pc", ipc, 32'h0); check("seq0_word", word, ADD);
    tick(); check("seq1_pc", ipc, 32'h4); check("seq1_word", word, SUB);
    tick(); check("seq2_pc", ipc, 32'h8); check("seq2_word", word, XOR);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", valid, 1); check("stall_pc", ipc, 32'h8); check("stall_word", word, XOR);
    end
    rdy = 1'b1;
    tick(); check("seq3_valid", valid, 1); check("seq3_pc", ipc, 32'hC); check("seq3_word", word, OR);

    // redirect discards an unaccepted instruction
    rv = 1'b1; rpc = 32'h4;
    tick(); rv = 1'b0;
    check("redir_a_valid", valid, 0);
    tick(); check("redir_a_pc", ipc, 32'h4); check("redir_a_word", word, SUB);
    rdy = 1'b0; rv = 1'b1; rpc = 32'h10;
    tick(); rv = 1'b0; rdy = 1'b1;
    check("redir_drop_valid", valid, 0); check("redir_b_misalign", misalign, 0);
    tick(); check("redir_b_valid", valid, 1); check("redir_b_pc", ipc, 32'h10); check("redir_b_word", word, mem[4]);

    // misaligned redirect: one-cycle pulse, fetch from the aligned word
    rv = 1'b1; rpc = 32'hE;
    tick(); rv = 1'b0;
    check("mis_pulse", misalign, 1); check("mis_valid", valid, 0);
    tick(); check("mis_clear", misalign, 0); check("mis_pc", ipc, 32'hC); check("mis_word", word, OR);

    // randomized run against the instruction-stream model
    next_pc = 32'h10;
    for (int i = 0; i < 600; i++) begin
      p_valid = valid; p_halted = halted; p_pc = ipc; p_word = word;
      rv = ($urandom_range(0, 15) == 0);
      rpc = $urandom_range(0, 'h4F);
      rdy = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 7) == 0);
      waddr = 4'($urandom_range(0, 15));
      wdata = $urandom;
      tick();
      check("rnd_misalign", misalign, 32'(rv && (rpc[1:0] != 2'b00)));
      if (rv) begin
        check("rnd_redir_valid", valid, 0);
        check("rnd_redir_halted", halted, 0);
        next_pc = {rpc[31:2], 2'b00};
      end else if (p_halted) begin
        check("rnd_halt_hold", halted, 1);
        check("rnd_halt_valid", valid, 0);
      end else if (p_valid && !rdy) begin
        check("rnd_hold_valid", valid, 1);
        check("rnd_hold_pc", ipc, p_pc);
        check("rnd_hold_word", word, p_word);
      end else if (next_pc >= 32'h40) begin
        check("rnd_halt_enter", halted, 1);
        check("rnd_halt_nofetch", valid, 0);
      end else begin
        check("rnd_fetch_valid", valid, 1);
        check("rnd_fetch_pc", ipc, next_pc);
        check("rnd_fetch_word", word, mem[next_pc[5:2]]);
        next_pc = next_pc + 32'd4;
      end
      if (we) mem[waddr] = wdata;
    end
    rv = 1'b0; we = 1'b0;

    // reset in the middle of a stall, then perf counting
    rdy = 1'b0; rv = 1'b1; rpc = 32'h20;
    tick(); rv = 1'b0;
    tick(); tick();
    check("prerst_valid", valid, 1); check("prerst_pc", ipc, 32'h20);
    reset_n = 1'b0;
    tick();
    check("midrst_valid", valid, 0); check("midrst_pc", ipc, 0);
`ifdef IFU_PERF_CNT_EN
    check("midrst_fetch_cnt", fetch_cnt, 0); check("midrst_stall_cnt", stall_cnt, 0);
`endif
    reset_n = 1'b1;
    tick(); tick();
    check("postrst_pc", ipc, 32'h0); check("postrst_word", word, mem[0]);
    tick(); tick(); tick();
    rdy = 1'b1;
    tick(); tick(); tick(); tick();
    check("perfseq_pc", ipc, 32'h10); check("perfseq_word", word, mem[4]);
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch", fetch_cnt, 4); check("perf_stall", stall_cnt, 3);
`endif

    // depth-4 unit runs off the end of memory and restarts on redirect
    reset2_n = 1'b1;
    tick();
    check("d4_boot", valid2, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("d4_valid", valid2, 1); check("d4_pc", ipc2, 32'(4 * k)); check("d4_word", word2, mem2[k]);
      check("d4_not_halted", halted2, 0);
    end
    tick(); check("d4_halted", halted2, 1); check("d4_halt_valid", valid2, 0);
    tick(); check("d4_halt_stay", halted2, 1); check("d4_halt_stay_valid", valid2, 0);
    rv2 = 1'b1; rpc2 = 32'h0;
    tick(); rv2 = 1'b0;
    check("d4_unhalt", halted2, 0); check("d4_unhalt_valid", valid2, 0);
    tick(); check("d4_restart_valid", valid2, 1); check("d4_restart_pc", ipc2, 32'h0);
    check("d4_restart_word", word2, ADD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
